// File: rtl/branch_resolver_pkg.sv
// Shared pipeline-control definitions: branch_jump codes, resolver state, XLEN.
// Latency: n/a (types and constants only).
// Backpressure: n/a. The flush logic imports the same code constants.
package pipe_ctrl_pkg;

  localparam int XLEN   = 32;
  localparam int CODE_W = 2;

  typedef logic [CODE_W-1:0] bj_code_t;

  localparam bj_code_t BJ_NONE   = 2'd0;
  localparam bj_code_t BJ_BRANCH = 2'd1;
  localparam bj_code_t BJ_JUMP   = 2'd2;
  localparam bj_code_t BJ_JR     = 2'd3;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } br_state_e;

  // PC-relative branch target; the carry out of bit 31 is dropped.
  function automatic logic [XLEN-1:0] branch_target(input logic [XLEN-1:0] pc_plus4,
                                                    input logic [XLEN-1:0] imm_sext);
    return pc_plus4 + (imm_sext << 2);
  endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// EX -> resolver -> fetch bundle: instruction in (valid/ready), redirect out (valid/ready).
// Latency: n/a (wiring only).
// Backpressure: in_ready from resolver, redirect_ready from fetch.
// Modports: slave = resolver side, master = EX/fetch side.
interface branch_resolver_if;
  import pipe_ctrl_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic            is_beq;
  logic            is_bne;
  logic            is_j;
  logic            is_jr;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] imm_sext;
  logic [25:0]     jidx;
  logic            redirect_valid;
  logic            redirect_ready;
  logic [XLEN-1:0] redirect_pc;
  bj_code_t        branch_jump;

  modport slave (
    input  in_valid, is_beq, is_bne, is_j, is_jr,
    input  rs_val, rt_val, pc_plus4, imm_sext, jidx,
    input  redirect_ready,
    output in_ready, redirect_valid, redirect_pc, branch_jump
  );

  modport master (
    output in_valid, is_beq, is_bne, is_j, is_jr,
    output rs_val, rt_val, pc_plus4, imm_sext, jidx,
    output redirect_ready,
    input  in_ready, redirect_valid, redirect_pc, branch_jump
  );

endinterface

// File: rtl/branch_resolver_target_calc.sv
// target_calc: decides taken, target PC and branch_jump code for one instruction.
// Latency: combinational.
// Backpressure: none; the caller qualifies results with its own handshake.
// Ports: decode flags + operands in; taken, target, code out.
module target_calc
  import pipe_ctrl_pkg::*;
(
  input  logic            is_beq,
  input  logic            is_bne,
  input  logic            is_j,
  input  logic            is_jr,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] imm_sext,
  input  logic [25:0]     jidx,
  output logic            taken,
  output logic [XLEN-1:0] target,
  output bj_code_t        code
);

  logic operands_eq;
  assign operands_eq = (rs_val == rt_val);

  // Priority jr > j > beq > bne so an illegal multi-flag encoding still
  // resolves deterministically.
  always_comb begin
    taken  = 1'b0;
    target = '0;
    code   = BJ_NONE;
    if (is_jr) begin
      taken  = 1'b1;
      target = rs_val;
      code   = BJ_JR;
    end else if (is_j) begin
      taken  = 1'b1;
      target = {pc_plus4[31:28], jidx, 2'b00};
      code   = BJ_JUMP;
    end else if (is_beq || is_bne) begin
      taken  = is_beq ? operands_eq : !operands_eq;
      target = branch_target(pc_plus4, imm_sext);
      code   = taken ? BJ_BRANCH : BJ_NONE;
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: resolves EX control transfers, holds a redirect toward fetch.
// Latency: 1 cycle from accepted taken transfer to redirect_valid.
// Backpressure: in_ready low while a redirect is pending; redirect held until redirect_ready.
// Ports: clk, rst_n (async active-low), bus (branch_resolver_if.slave).
// Optional: BRANCH_RESOLVER_STATS_EN adds stat_resolved/stat_taken/stat_jumps counters.
module branch_resolver
  import pipe_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  branch_resolver_if.slave    bus
`ifdef BRANCH_RESOLVER_STATS_EN
  ,
  output logic [31:0]         stat_resolved,
  output logic [31:0]         stat_taken,
  output logic [31:0]         stat_jumps
`endif
);

  br_state_e       state_q;
  br_state_e       state_d;
  logic            taken;
  logic [XLEN-1:0] target;
  bj_code_t        code;
  logic            accept;
  logic            load;
  logic            handshake;
  logic [XLEN-1:0] pc_q;
  bj_code_t        bj_q;

  target_calc u_target_calc (
    .is_beq   (bus.is_beq),
    .is_bne   (bus.is_bne),
    .is_j     (bus.is_j),
    .is_jr    (bus.is_jr),
    .rs_val   (bus.rs_val),
    .rt_val   (bus.rt_val),
    .pc_plus4 (bus.pc_plus4),
    .imm_sext (bus.imm_sext),
    .jidx     (bus.jidx),
    .taken    (taken),
    .target   (target),
    .code     (code)
  );

  assign accept    = bus.in_valid && bus.in_ready;
  assign load      = accept && taken;
  assign handshake = (state_q == PENDING) && bus.redirect_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state; redirect_ready in IDLE has no effect.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load)               state_d = PENDING;
      PENDING: if (bus.redirect_ready) state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  // Outputs decoded from state only, so in_ready never depends on in_valid.
  always_comb begin
    bus.in_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    case (state_q)
      IDLE:    bus.in_ready       = 1'b1;
      PENDING: bus.redirect_valid = 1'b1;
      default: bus.in_ready       = 1'b0;
    endcase
  end

  // Redirect payload: captured on load, frozen while pending, zeroed on
  // handshake so branch_jump is nonzero only alongside redirect_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
      bj_q <= BJ_NONE;
    end else if (load) begin
      pc_q <= target;
      bj_q <= code;
    end else if (handshake) begin
      pc_q <= '0;
      bj_q <= BJ_NONE;
    end
  end

  assign bus.redirect_pc = pc_q;
  assign bus.branch_jump = bj_q;

`ifdef BRANCH_RESOLVER_STATS_EN
  logic is_jump;
  logic is_branch;
  assign is_jump   = bus.is_j || bus.is_jr;
  assign is_branch = !is_jump && (bus.is_beq || bus.is_bne);

  // Counters wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_resolved <= '0;
      stat_taken    <= '0;
      stat_jumps    <= '0;
    end else if (accept) begin
      if (is_jump || is_branch)  stat_resolved <= stat_resolved + 32'd1;
      if (is_branch && taken)    stat_taken    <= stat_taken + 32'd1;
      if (is_jump)               stat_jumps    <= stat_jumps + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: directed vectors push expected redirects,
// a negedge monitor pops and compares on every redirect handshake.
module tb_branch_resolver;
  import pipe_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  code;
  } exp_t;
  exp_t exp_q[$];

  branch_resolver_if bus ();

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] stat_resolved;
  logic [31:0] stat_taken;
  logic [31:0] stat_jumps;
  branch_resolver dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .stat_resolved(stat_resolved), .stat_taken(stat_taken), .stat_jumps(stat_jumps)
  );
`else
  branch_resolver dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every handshake pops one expected redirect; idle outputs must be zero.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.redirect_valid && bus.redirect_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_redirect: got pc 0x%08h code %0d, expected none",
                   bus.redirect_pc, bus.branch_jump);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_redirect_pc", bus.redirect_pc, e.pc);
          chk("sb_branch_jump", {30'd0, bus.branch_jump}, {30'd0, e.code});
        end
      end
      if (!bus.redirect_valid) begin
        chk("idle_branch_jump_zero", {30'd0, bus.branch_jump}, 32'd0);
        chk("idle_redirect_pc_zero", bus.redirect_pc, 32'd0);
      end
    end
  end

  task automatic clear_in();
    bus.in_valid = 1'b0;
    bus.is_beq   = 1'b0;
    bus.is_bne   = 1'b0;
    bus.is_j     = 1'b0;
    bus.is_jr    = 1'b0;
    bus.rs_val   = '0;
    bus.rt_val   = '0;
    bus.pc_plus4 = '0;
    bus.imm_sext = '0;
    bus.jidx     = '0;
  endtask

  task automatic set_in(input logic beq, input logic bne, input logic j, input logic jr,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] pc4, input logic [31:0] imm,
                        input logic [25:0] ji);
    bus.in_valid = 1'b1;
    bus.is_beq   = beq;
    bus.is_bne   = bne;
    bus.is_j     = j;
    bus.is_jr    = jr;
    bus.rs_val   = rs;
    bus.rt_val   = rt;
    bus.pc_plus4 = pc4;
    bus.imm_sext = imm;
    bus.jidx     = ji;
  endtask

  // Present one instruction for exactly one clock edge (resolver must be idle).
  task automatic offer(input logic beq, input logic bne, input logic j, input logic jr,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] pc4, input logic [31:0] imm,
                       input logic [25:0] ji);
    @(posedge clk); #1;
    set_in(beq, bne, j, jr, rs, rt, pc4, imm, ji);
    @(posedge clk); #1;
    clear_in();
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [1:0] code);
    exp_t e;
    e.pc   = pc;
    e.code = code;
    exp_q.push_back(e);
  endtask

  task automatic check_hold(input int n, input logic [31:0] epc, input logic [1:0] ecode);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, bus.redirect_valid}, 32'd1);
      chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("hold_pc", bus.redirect_pc, epc);
      chk("hold_code", {30'd0, bus.branch_jump}, {30'd0, ecode});
    end
  endtask

  task automatic ack();
    @(posedge clk); #1;
    bus.redirect_ready = 1'b1;
    @(posedge clk); #1;
    bus.redirect_ready = 1'b0;
    @(negedge clk);
    chk("post_ack_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("post_ack_valid", {31'd0, bus.redirect_valid}, 32'd0);
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    chk({name, "_valid"}, {31'd0, bus.redirect_valid}, 32'd0);
    chk({name, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    chk({name, "_code"}, {30'd0, bus.branch_jump}, 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clear_in();
    bus.redirect_ready = 1'b0;
    rst_n = 1'b0;

    // Reset state
    @(negedge clk);
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("reset_valid", {31'd0, bus.redirect_valid}, 32'd0);
    chk("reset_pc", bus.redirect_pc, 32'd0);
    chk("reset_code", {30'd0, bus.branch_jump}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // BEQ taken, backward offset
    push_exp(32'h0040_0000, BJ_BRANCH);
    offer(1, 0, 0, 0, 32'h5, 32'h5, 32'h0040_0010, 32'hFFFF_FFFC, 26'h0);
    check_hold(1, 32'h0040_0000, BJ_BRANCH);
    ack();

    // BNE not taken
    offer(0, 1, 0, 0, 32'h7, 32'h7, 32'h0040_0010, 32'h4, 26'h0);
    check_idle("bne_nt");

    // J
    push_exp(32'h1000_0400, BJ_JUMP);
    offer(0, 0, 1, 0, 32'h0, 32'h0, 32'h1000_0004, 32'h0, 26'h000_0100);
    check_hold(1, 32'h1000_0400, BJ_JUMP);
    ack();

    // JR held 3 cycles while a taken BEQ is offered and must be ignored
    push_exp(32'h0040_0080, BJ_JR);
    offer(0, 0, 0, 1, 32'h0040_0080, 32'h0, 32'h0, 32'h0, 26'h0);
    set_in(1, 0, 0, 0, 32'h1, 32'h1, 32'h0000_1000, 32'h10, 26'h0);
    check_hold(3, 32'h0040_0080, BJ_JR);
    @(posedge clk); #1;
    clear_in();
    ack();

    // BNE taken with target wrapping past 2^32
    push_exp(32'h0000_0010, BJ_BRANCH);
    offer(0, 1, 0, 0, 32'h1, 32'h2, 32'hFFFF_FFF0, 32'h8, 26'h0);
    check_hold(1, 32'h0000_0010, BJ_BRANCH);
    ack();

    // Multiple flags: JR wins, unaligned target passed through
    push_exp(32'h0040_0083, BJ_JR);
    offer(1, 0, 1, 1, 32'h0040_0083, 32'h0040_0083, 32'h1000_0004, 32'h4, 26'h3FF_FFFF);
    check_hold(2, 32'h0040_0083, BJ_JR);
    ack();

    // in_valid with no flag set
    offer(0, 0, 0, 0, 32'h1, 32'h1, 32'h100, 32'h4, 26'h1);
    check_idle("no_flag");

    // Reset while pending: redirect discarded immediately
    offer(0, 0, 1, 0, 32'h0, 32'h0, 32'h3000_0000, 32'h0, 26'h000_0040);
    @(negedge clk);
    chk("pre_reset_valid", {31'd0, bus.redirect_valid}, 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", {31'd0, bus.redirect_valid}, 32'd0);
    chk("async_reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("async_reset_pc", bus.redirect_pc, 32'd0);
    chk("async_reset_code", {30'd0, bus.branch_jump}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_idle("after_reset");

    // Stats traffic: 2 taken BEQ, 1 not-taken BNE, 1 J
    push_exp(32'h0000_0104, BJ_BRANCH);
    offer(1, 0, 0, 0, 32'h9, 32'h9, 32'h0000_0100, 32'h1, 26'h0);
    ack();
    push_exp(32'h0000_01FC, BJ_BRANCH);
    offer(1, 0, 0, 0, 32'h0, 32'h0, 32'h0000_0200, 32'hFFFF_FFFF, 26'h0);
    ack();
    offer(0, 1, 0, 0, 32'h3, 32'h3, 32'h0000_0300, 32'h4, 26'h0);
    check_idle("stats_bne_nt");
    push_exp(32'h2FFF_FFFC, BJ_JUMP);
    offer(0, 0, 1, 0, 32'h0, 32'h0, 32'h2000_0000, 32'h0, 26'h3FF_FFFF);
    check_hold(1, 32'h2FFF_FFFC, BJ_JUMP);
    ack();

`ifdef BRANCH_RESOLVER_STATS_EN
    @(negedge clk);
    chk("stat_resolved", stat_resolved, 32'd4);
    chk("stat_taken", stat_taken, 32'd2);
    chk("stat_jumps", stat_jumps, 32'd1);
`endif

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
